// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IF_req;
  logic [ADDR_W-1:0] IF_addr;
  logic              IF_kill;
  logic [DATA_W-1:0] IF_rdata;
  logic              IF_ack;

  logic                D_req;
  logic                D_we;
  logic [DATA_W/8-1:0] D_be;
  logic [ADDR_W-1:0]   D_addr;
  logic [DATA_W-1:0]   D_wdata;
  logic [DATA_W-1:0]   D_rdata;
  logic                D_ack;

  logic                MEM_valid;
  logic                MEM_ready;
  logic                MEM_we;
  logic [DATA_W/8-1:0] MEM_be;
  logic [ADDR_W-1:0]   MEM_addr;
  logic [DATA_W-1:0]   MEM_wdata;
  logic                MEM_rvalid;
  logic [DATA_W-1:0]   MEM_rdata;

  logic FETCH_stall;
  logic MEM_stall;

  modport slave (
    input  IF_req, IF_addr, IF_kill,
    output IF_rdata, IF_ack,
    input  D_req, D_we, D_be, D_addr, D_wdata,
    output D_rdata, D_ack,
    output MEM_valid, MEM_we, MEM_be, MEM_addr, MEM_wdata,
    input  MEM_ready, MEM_rvalid, MEM_rdata,
    output FETCH_stall, MEM_stall
  );

  modport master (
    output IF_req, IF_addr, IF_kill,
    input  IF_rdata, IF_ack,
    output D_req, D_we, D_be, D_addr, D_wdata,
    input  D_rdata, D_ack,
    input  MEM_valid, MEM_we, MEM_be, MEM_addr, MEM_wdata,
    output MEM_ready, MEM_rvalid, MEM_rdata,
    input  FETCH_stall, MEM_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single external memory port shared by fetch and load/store, one transaction at a time,
// data-first with a starvation bound for fetch. Optional fetch kill: ARB_FETCH_KILL_EN.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int         BE_W    = DATA_W / 8;
  localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              kill_now_s;

`ifdef ARB_FETCH_KILL_EN
  logic kill_q;
  logic kill_set_s;

  assign kill_set_s = (state_q != ST_IDLE) && (owner_q == OWN_IF) && bus.IF_kill;
  assign kill_now_s = kill_q | kill_set_s;

  // Kill flag: armed while fetch owns the port, dropped once back in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      kill_q <= 1'b0;
    end else if (kill_set_s) begin
      kill_q <= 1'b1;
    end else begin
      kill_q <= kill_q;
    end
  end
`else
  assign kill_now_s = 1'b0;
`endif

  // Next-state, grant and response decode.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data wins unless fetch has already waited out MAX_D_BURST data grants.
        if (bus.D_req && !(bus.IF_req && (cnt_q == MAX_CNT))) begin
          owner_d = OWN_D;
          state_d = ST_REQ;
          valid_d = 1'b1;
          we_d    = bus.D_we;
          be_d    = bus.D_be;
          addr_d  = bus.D_addr;
          wdata_d = bus.D_wdata;
          if (bus.IF_req) begin
            cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end else if (bus.IF_req) begin
          owner_d = OWN_IF;
          state_d = ST_REQ;
          valid_d = 1'b1;
          we_d    = 1'b0;
          be_d    = {BE_W{1'b1}};
          addr_d  = bus.IF_addr;
          wdata_d = {DATA_W{1'b0}};
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.MEM_ready) begin
          valid_d = 1'b0;
          if (we_q) begin
            state_d = ST_RESP;
            d_ack_d = (owner_q == OWN_D);
          end else begin
            state_d = ST_WAIT_R;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_R: begin
        if (bus.MEM_rvalid) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = bus.MEM_rdata;
            d_ack_d   = 1'b1;
          end else if (!kill_now_s) begin
            if_rdata_d = bus.MEM_rdata;
            if_ack_d   = 1'b1;
          end else begin
            if_ack_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT_R;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= 4'd0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= {BE_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      if_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q  <= {DATA_W{1'b0}};
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  assign bus.MEM_valid   = valid_q;
  assign bus.MEM_we      = we_q;
  assign bus.MEM_be      = be_q;
  assign bus.MEM_addr    = addr_q;
  assign bus.MEM_wdata   = wdata_q;
  assign bus.IF_rdata    = if_rdata_q;
  assign bus.IF_ack      = if_ack_q;
  assign bus.D_rdata     = d_rdata_q;
  assign bus.D_ack       = d_ack_q;
  assign bus.FETCH_stall = bus.IF_req & ~if_ack_q;
  assign bus.MEM_stall   = bus.D_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
`ifdef ARB_FETCH_KILL_EN
  localparam bit KILL_EN = 1'b1;
`else
  localparam bit KILL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  int          ready_gap    = 0;
  bit          rsp_enable   = 1'b1;
  bit          rsp_due      = 1'b0;
  bit          rvalid_pulse = 1'b0;
  logic [31:0] rsp_data     = 32'h0;

  always @(negedge clk) begin
    bus.MEM_rvalid = 1'b0;
    if (rsp_due) begin
      rsp_due        = 1'b0;
      bus.MEM_rvalid = rsp_enable;
      bus.MEM_rdata  = rsp_data;
    end
    if (rvalid_pulse) begin
      rvalid_pulse   = 1'b0;
      bus.MEM_rvalid = 1'b1;
      bus.MEM_rdata  = 32'h5555_AAAA;
    end
    if (bus.MEM_valid && ready_gap > 0) begin
      bus.MEM_ready = 1'b0;
      ready_gap--;
    end else begin
      bus.MEM_ready = 1'b1;
    end
    if (bus.MEM_valid && bus.MEM_ready && !bus.MEM_we) rsp_due = 1'b1;
  end

  // ---------------- reference model ----------------
  // phase: 0 nothing in flight, 1 request offered, 2 read awaiting data, 3 completing
  int          m_phase  = 0;
  bit          m_own_d  = 1'b0;
  int          m_streak = 0;
  bit          m_kill   = 1'b0;
  logic        e_valid, e_we, e_if_ack, e_d_ack;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0; m_own_d <= 1'b0; m_streak <= 0; m_kill <= 1'b0;
      e_valid <= 1'b0; e_we <= 1'b0; e_be <= 4'h0; e_addr <= 32'h0; e_wdata <= 32'h0;
      e_if_ack <= 1'b0; e_d_ack <= 1'b0; e_if_rdata <= 32'h0; e_d_rdata <= 32'h0;
    end else begin
      e_if_ack <= 1'b0;
      e_d_ack  <= 1'b0;
      if (m_phase == 0) begin
        m_kill <= 1'b0;
        if (bus.D_req && (!bus.IF_req || m_streak < MAXB)) begin
          m_own_d <= 1'b1; m_phase <= 1; e_valid <= 1'b1;
          e_we <= bus.D_we; e_be <= bus.D_be; e_addr <= bus.D_addr; e_wdata <= bus.D_wdata;
          m_streak <= bus.IF_req ? m_streak + 1 : 0;
        end else if (bus.IF_req) begin
          m_own_d <= 1'b0; m_phase <= 1; e_valid <= 1'b1;
          e_we <= 1'b0; e_be <= 4'hF; e_addr <= bus.IF_addr; e_wdata <= 32'h0;
          m_streak <= 0;
        end
      end else if (m_phase == 1) begin
        if (KILL_EN && !m_own_d && bus.IF_kill) m_kill <= 1'b1;
        if (bus.MEM_ready) begin
          e_valid <= 1'b0;
          if (e_we) begin m_phase <= 3; e_d_ack <= 1'b1; end
          else m_phase <= 2;
        end
      end else if (m_phase == 2) begin
        if (KILL_EN && !m_own_d && bus.IF_kill) m_kill <= 1'b1;
        if (bus.MEM_rvalid) begin
          m_phase <= 3;
          if (m_own_d) begin
            e_d_rdata <= bus.MEM_rdata; e_d_ack <= 1'b1;
          end else if (!(m_kill || (KILL_EN && bus.IF_kill))) begin
            e_if_rdata <= bus.MEM_rdata; e_if_ack <= 1'b1;
          end
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("MEM_valid", bus.MEM_valid, e_valid);
      if (e_valid) begin
        chk("MEM_we", bus.MEM_we, e_we);
        chk("MEM_be", bus.MEM_be, e_be);
        chk("MEM_addr", bus.MEM_addr, e_addr);
        chk("MEM_wdata", bus.MEM_wdata, e_wdata);
      end
      chk("IF_ack", bus.IF_ack, e_if_ack);
      chk("D_ack", bus.D_ack, e_d_ack);
      chk("IF_rdata", bus.IF_rdata, e_if_rdata);
      chk("D_rdata", bus.D_rdata, e_d_rdata);
      chk("FETCH_stall", bus.FETCH_stall, bus.IF_req & ~e_if_ack);
      chk("MEM_stall", bus.MEM_stall, bus.D_req & ~e_d_ack);
    end
  end

  // Grant order recorder: 1 = data, 0 = fetch (told apart by address).
  bit gq[$];
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    #2;
    if (bus.MEM_valid && !prev_v) gq.push_back(bus.MEM_addr == 32'h400);
    prev_v = bus.MEM_valid;
  end

  task automatic wait_ack(input bit is_d, input int budget);
    int n = 0;
    while (((is_d ? bus.D_ack : bus.IF_ack) !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    chk(is_d ? "D_ack_wait" : "IF_ack_wait", is_d ? bus.D_ack : bus.IF_ack, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    step();
    rsp_data = data; bus.IF_addr = addr; bus.IF_req = 1'b1;
    step();
    wait_ack(1'b0, 20);
    chk("fetch_rdata", bus.IF_rdata, data);
    bus.IF_req = 1'b0;
  endtask

  bit exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    rst_n = 1'b0;
    bus.IF_req = 1'b0; bus.IF_addr = 32'h0; bus.IF_kill = 1'b0;
    bus.D_req = 1'b0; bus.D_we = 1'b0; bus.D_be = 4'h0; bus.D_addr = 32'h0; bus.D_wdata = 32'h0;
    bus.MEM_ready = 1'b1; bus.MEM_rvalid = 1'b0; bus.MEM_rdata = 32'h0;
    @(posedge clk);
    chk_en = 1'b1;
    step();
    chk("rst_MEM_valid", bus.MEM_valid, 32'd0);
    chk("rst_IF_ack", bus.IF_ack, 32'd0);
    chk("rst_D_ack", bus.D_ack, 32'd0);
    chk("rst_IF_rdata", bus.IF_rdata, 32'd0);
    chk("rst_D_rdata", bus.D_rdata, 32'd0);
    chk("rst_MEM_addr", bus.MEM_addr, 32'd0);
    step();
    rst_n = 1'b1;

    // Single fetch: valid at cycle 1, ack at cycle 3.
    step();
    bus.IF_addr = 32'h100; bus.IF_req = 1'b1; rsp_data = 32'hDEAD_BEEF;
    #1 chk("fetch_stall_c0", bus.FETCH_stall, 32'd1);
    step();
    chk("fetch_valid_c1", bus.MEM_valid, 32'd1);
    chk("fetch_addr_c1", bus.MEM_addr, 32'h100);
    chk("fetch_stall_c1", bus.FETCH_stall, 32'd1);
    step();
    chk("fetch_stall_c2", bus.FETCH_stall, 32'd1);
    chk("fetch_noack_c2", bus.IF_ack, 32'd0);
    step();
    chk("fetch_ack_c3", bus.IF_ack, 32'd1);
    chk("fetch_rdata_c3", bus.IF_rdata, 32'hDEAD_BEEF);
    bus.IF_req = 1'b0;

    // Store with three cycles of backpressure.
    step();
    ready_gap = 3;
    bus.D_we = 1'b1; bus.D_be = 4'b0011; bus.D_addr = 32'h200; bus.D_wdata = 32'h1234; bus.D_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("st_valid", bus.MEM_valid, 32'd1);
      chk("st_we", bus.MEM_we, 32'd1);
      chk("st_be", bus.MEM_be, 32'h3);
      chk("st_addr", bus.MEM_addr, 32'h200);
      chk("st_wdata", bus.MEM_wdata, 32'h1234);
      chk("st_noack", bus.D_ack, 32'd0);
    end
    step();
    chk("st_ack", bus.D_ack, 32'd1);
    chk("st_D_rdata", bus.D_rdata, 32'd0);
    chk("st_IF_rdata", bus.IF_rdata, 32'hDEAD_BEEF);
    bus.D_req = 1'b0;

    // Contention: both held high, expect D D D D IF D D D D IF.
    step();
    gq.delete();
    rsp_data = 32'h7777_0000;
    bus.IF_addr = 32'h300; bus.IF_req = 1'b1;
    bus.D_we = 1'b0; bus.D_be = 4'hF; bus.D_addr = 32'h400; bus.D_wdata = 32'h0; bus.D_req = 1'b1;
    n = 0;
    while (gq.size() < 10 && n < 200) begin
      step();
      n++;
    end
    chk("grant_count", gq.size(), 32'd10);
    for (int i = 0; i < 10 && i < gq.size(); i++) chk($sformatf("grant_order_%0d", i), gq[i], exp_order[i]);
    wait_ack(1'b0, 20);
    bus.IF_req = 1'b0;
    wait_ack(1'b1, 20);
    bus.D_req = 1'b0;

    // Stall: D request arrives while the fetch waits for data.
    step();
    bus.IF_addr = 32'h500; bus.IF_req = 1'b1; rsp_data = 32'h1111_2222;
    step();
    step();
    bus.D_we = 1'b0; bus.D_be = 4'hF; bus.D_addr = 32'h600; bus.D_req = 1'b1;
    #1 chk("stall_rise", bus.MEM_stall, 32'd1);
    step();
    chk("stall_if_ack", bus.IF_ack, 32'd1);
    bus.IF_req = 1'b0; rsp_data = 32'h3333_4444;
    for (int k = 4; k <= 6; k++) begin
      step();
      chk("stall_hold", bus.MEM_stall, 32'd1);
      chk("stall_noack", bus.D_ack, 32'd0);
    end
    step();
    chk("stall_d_ack", bus.D_ack, 32'd1);
    chk("stall_d_rdata", bus.D_rdata, 32'h3333_4444);
    chk("stall_clear", bus.MEM_stall, 32'd0);
    bus.D_req = 1'b0;

    // Fetch kill in WAIT_R, same cycle as the read response.
    step();
    bus.IF_addr = 32'h900; bus.IF_req = 1'b1; rsp_data = 32'hCAFE_F00D;
    step();
    step();
    bus.IF_kill = 1'b1;
    step();
    bus.IF_kill = 1'b0;
    chk("kill_ack", bus.IF_ack, KILL_EN ? 32'd0 : 32'd1);
    chk("kill_rdata", bus.IF_rdata, KILL_EN ? 32'h1111_2222 : 32'hCAFE_F00D);
    bus.IF_req = 1'b0;
    step();
    chk("kill_after", bus.IF_ack, 32'd0);

    // Reset in WAIT_R, then a stray response in IDLE.
    step();
    rsp_enable = 1'b0;
    bus.IF_addr = 32'h700; bus.IF_req = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("rmid_ack", bus.IF_ack, 32'd0);
    chk("rmid_valid", bus.MEM_valid, 32'd0);
    chk("rmid_IF_rdata", bus.IF_rdata, 32'd0);
    chk("rmid_D_rdata", bus.D_rdata, 32'd0);
    rst_n = 1'b1; bus.IF_req = 1'b0; rsp_enable = 1'b1; rvalid_pulse = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rmid_no_if_ack", bus.IF_ack, 32'd0);
      chk("rmid_no_d_ack", bus.D_ack, 32'd0);
    end
    do_fetch(32'h800, 32'h0BAD_F00D);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port between instruction fetch (IF) and the MEM-stage load/store unit (D).
- Sequences one outstanding transaction at a time, returns read data to the winning requester, and drives per-requester stall signals into the hazard unit.
- Data accesses take priority; a bounded starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_D_BURST, 4, consecutive data grants allowed while IF_req is pending before fetch is forced to win; legal range 1..15

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- IF_req  input  1  fetch request, held until IF_ack
- IF_addr  input  ADDR_W  fetch address, stable while IF_req is high
- IF_kill  input  1  discard the in-flight fetch (see Optional Feature)
- IF_rdata  output  DATA_W  fetched word, valid when IF_ack is high
- IF_ack  output  1  one-cycle fetch completion pulse
- D_req  input  1  load/store request, held until D_ack
- D_we  input  1  1 = store, 0 = load
- D_be  input  DATA_W/8  store byte enables
- D_addr  input  ADDR_W  data address
- D_wdata  input  DATA_W  store data
- D_rdata  output  DATA_W  load data, valid when D_ack is high
- D_ack  output  1  one-cycle data completion pulse
- MEM_valid  output  1  port request valid
- MEM_ready  input  1  port accepts request when MEM_valid & MEM_ready
- MEM_we, MEM_be, MEM_addr, MEM_wdata  output  1/DATA_W/8/ADDR_W/DATA_W  registered request fields
- MEM_rvalid  input  1  read response valid
- MEM_rdata  input  DATA_W  read response data
- FETCH_stall  output  1  IF_req & ~IF_ack (combinational)
- MEM_stall  output  1  D_req & ~D_ack (combinational)

Behaviour:
- States: IDLE, REQ, WAIT_R, RESP.
- Reset (rst_n low at a clk edge): state IDLE; MEM_valid, IF_ack, D_ack = 0; MEM_* fields, IF_rdata, D_rdata = 0; owner = IF; starvation count = 0. Reset mid-transaction abandons it; any MEM_rvalid arriving in IDLE is ignored.
- IDLE:
  - If neither requester is asserted, remain in IDLE.
  - If only one requester is asserted, grant it.
  - If both are asserted, grant D unless count == MAX_D_BURST, in which case grant IF.
  - On grant, latch owner and request fields into the MEM_* registers, set MEM_valid = 1, and go to REQ.
- Starvation count:
  - On a D grant with IF_req high: count++ (saturating at MAX_D_BURST).
  - On an IF grant, or on a D grant with IF_req low: count = 0.
- REQ:
  - Hold MEM_valid and all fields stable until MEM_valid & MEM_ready.
  - On that handshake: MEM_valid = 0; a store goes to RESP, a read goes to WAIT_R.
  - If MEM_rvalid arrives in the same cycle as MEM_ready, it is ignored; the response must come at least one cycle later.
- WAIT_R: on MEM_rvalid, register MEM_rdata into the owner's rdata output and go to RESP.
- RESP:
  - Pulse the owner's ack for exactly one cycle, then go to IDLE.
  - Requests are not evaluated in RESP; a requester may change its address/req in the cycle after its ack.
- Minimum latency with MEM_ready = 1 at first offer and MEM_rvalid one cycle later:
  - Read: req seen at cycle 0, MEM_valid at cycle 1, rvalid at cycle 2, ack at cycle 3.
  - Store: ack at cycle 2.
- Back-to-back: the next grant occurs in the cycle after RESP (IDLE), giving a 4-cycle read throughput.
- IF_ack and D_ack are never both high. rdata holds its last value between acks.

Optional Feature:
- Macro ARB_FETCH_KILL_EN.
- Defined:
  - IF_kill high while IF is the owner (REQ, WAIT_R or RESP entry) sets a kill flag.
  - The transaction still completes on the port, so no protocol violation occurs.
  - IF_ack and the IF_rdata update are suppressed, and the FSM returns to IDLE.
  - The kill flag clears in IDLE.
  - IF_kill while D is the owner has no effect.
- Undefined: IF_kill is ignored; the port remains for a uniform interface.

Test Plan:
- Single fetch: IF_req = 1, IF_addr = 0x100, MEM_ready = 1, rvalid next cycle with rdata = 0xDEADBEEF -> MEM_valid at cycle 1 with MEM_addr = 0x100; IF_ack = 1 and IF_rdata = 0xDEADBEEF at cycle 3; FETCH_stall = 1 during cycles 0-2.
- Store with backpressure: D_req = 1, D_we = 1, D_be = 4'b0011, D_addr = 0x200, D_wdata = 0x1234, MEM_ready low for 3 cycles -> MEM_* fields held stable for 4 cycles; D_ack 1 cycle after handshake; no read data updated.
- Contention/starvation: IF_req and D_req held high continuously, MAX_D_BURST = 4 -> grant order D, D, D, D, IF, D, D, D, D, IF; the count resets after each IF grant.
- Reset mid-read: assert rst_n = 0 in WAIT_R, release, then pulse MEM_rvalid -> no ack; outputs 0; state IDLE; the next IF_req is served normally.
- Fetch kill (ARB_FETCH_KILL_EN): IF owner in WAIT_R, IF_kill = 1 for one cycle, rvalid with 0xCAFEF00D -> IF_ack stays 0 and IF_rdata is unchanged. Without the macro -> IF_ack = 1 with 0xCAFEF00D.
- Stall outputs: D_req rises while the IF read is in WAIT_R -> MEM_stall = 1 until D_ack, which comes at RESP of the subsequent D transaction.
